// File: rtl/rand_engine_pkg.sv
// Purpose : shared constants and LFSR step function for the random-engine blocks.
// Latency : n/a (package, combinational helpers only).
// Backpr. : n/a.
// Contents: per-width default Galois taps/seeds (8/16/32 bits) and lfsr_step().
package rand_engine_pkg;

  // Widest LFSR the helpers support; narrower LFSRs are zero-extended into
  // this width and truncated back by the caller.
  localparam int unsigned MAX_NBITS = 32;

  // Maximal-length Galois feedback masks (right-shifting form).
  localparam logic [7:0]  TAPS_8  = 8'hB8;          // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x^1+1

  // Non-zero reset seeds.
  localparam logic [7:0]  SEED_8  = 8'hE1;
  localparam logic [15:0] SEED_16 = 16'hACE1;
  localparam logic [31:0] SEED_32 = 32'hACE1_ACE1;

  // Default taps for a given width. Widths other than 8/16/32 fall back to
  // the 16-bit mask, which is not maximal-length for them; such instances
  // are expected to pass their own TAPS.
  function automatic logic [MAX_NBITS-1:0] default_taps(input int unsigned nbits);
    logic [MAX_NBITS-1:0] t;
    t = MAX_NBITS'(TAPS_16);
    case (nbits)
      8:       t = MAX_NBITS'(TAPS_8);
      16:      t = MAX_NBITS'(TAPS_16);
      32:      t = TAPS_32;
      default: t = MAX_NBITS'(TAPS_16);
    endcase
    return t;
  endfunction

  function automatic logic [MAX_NBITS-1:0] default_seed(input int unsigned nbits);
    logic [MAX_NBITS-1:0] s;
    s = MAX_NBITS'(SEED_16);
    case (nbits)
      8:       s = MAX_NBITS'(SEED_8);
      16:      s = MAX_NBITS'(SEED_16);
      32:      s = SEED_32;
      default: s = MAX_NBITS'(SEED_16);
    endcase
    return s;
  endfunction

  // One Galois step: shift right, fold the mask in when the bit shifted out
  // was a 1. Upper bits above the caller's width stay zero as long as both
  // arguments are zero-extended.
  function automatic logic [MAX_NBITS-1:0] lfsr_step(input logic [MAX_NBITS-1:0] x,
                                                     input logic [MAX_NBITS-1:0] taps);
    return (x >> 1) ^ (x[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/random_engine_dpath_reg.sv
// Purpose : generic enabled state register with synchronous active-low reset.
// Latency : 1 cycle from d_i to q_o when en_i is high.
// Backpr. : none; holds q_o whenever en_i is low.
// Ports   : clk_i clock, rst_ni sync reset (low), en_i load enable,
//           d_i next value, q_o registered value.
module random_engine_dpath_reg #(
  parameter int unsigned     W         = 1,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/random_engine_dpath.sv
// Purpose : Galois LFSR datapath publishing each pre-step value as one sample
//           on a val/rdy stream through a single-entry output register.
// Latency : out_val rises the cycle after the first produce; then one sample
//           per cycle at full throughput (fire and produce in the same cycle).
// Backpr. : out_val && !out_rdy freezes out_msg, out_val and the LFSR, so no
//           sample is dropped or duplicated.
// Ports   : clk, rst (sync, active-low), lfsr_en (step enable, level),
//           seed_load/seed (reseed; zero seed replaced by SEED),
//           out_val/out_rdy/out_msg (sample stream), count (accepted samples, wraps).
module random_engine_dpath
  import rand_engine_pkg::*;
#(
  parameter int unsigned      NBITS   = 16,
  parameter logic [NBITS-1:0] TAPS    = NBITS'(default_taps(NBITS)),
  parameter logic [NBITS-1:0] SEED    = NBITS'(default_seed(NBITS)),
  parameter int unsigned      CNTBITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lfsr_en,
  input  logic               seed_load,
  input  logic [NBITS-1:0]   seed,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [NBITS-1:0]   out_msg,
  output logic [CNTBITS-1:0] count
);

  // NBITS must lie in 4..MAX_NBITS; the step helper works on MAX_NBITS bits.

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [NBITS-1:0]   lfsr_q,  lfsr_d;
  logic               lfsr_we;
  logic [NBITS-1:0]   msg_q,   msg_d;
  logic               msg_we;
  logic               val_q,   val_d;
  logic               val_we;
  logic [CNTBITS-1:0] count_q, count_d;
  logic               count_we;

  random_engine_dpath_reg #(
    .W         (NBITS),
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (lfsr_we),
    .d_i    (lfsr_d),
    .q_o    (lfsr_q)
  );

  random_engine_dpath_reg #(
    .W         (NBITS),
    .RESET_VAL ('0)
  ) u_msg (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (msg_we),
    .d_i    (msg_d),
    .q_o    (msg_q)
  );

  random_engine_dpath_reg #(
    .W         (1),
    .RESET_VAL (1'b0)
  ) u_val (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (val_we),
    .d_i    (val_d),
    .q_o    (val_q)
  );

  random_engine_dpath_reg #(
    .W         (CNTBITS),
    .RESET_VAL ('0)
  ) u_count (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (count_we),
    .d_i    (count_d),
    .q_o    (count_q)
  );

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  logic             fire;
  logic             slot_free;
  logic             produce;
  logic [NBITS-1:0] lfsr_stepped;
  logic [NBITS-1:0] seed_eff;

  // Helper runs at MAX_NBITS; zero-extend in and truncate out.
  assign lfsr_stepped = NBITS'(lfsr_step(MAX_NBITS'(lfsr_q), MAX_NBITS'(TAPS)));

  // An all-zero seed would lock the LFSR; substitute the reset seed.
  assign seed_eff = (seed == '0) ? SEED : seed;

  always_comb begin
    fire      = 1'b0;
    slot_free = 1'b0;
    produce   = 1'b0;
    lfsr_d    = lfsr_q;
    lfsr_we   = 1'b0;
    msg_d     = msg_q;
    msg_we    = 1'b0;
    val_d     = val_q;
    val_we    = 1'b0;
    count_d   = count_q;
    count_we  = 1'b0;

    fire      = val_q && out_rdy;
    // The output slot can take a new sample when empty or being drained now.
    slot_free = !val_q || fire;
    // A reseed cycle never produces: the sample would otherwise be the old
    // LFSR value, not the first value of the new sequence.
    produce   = lfsr_en && slot_free && !seed_load;

    if (seed_load) begin
      lfsr_d  = seed_eff;
      lfsr_we = 1'b1;
    end else if (produce) begin
      lfsr_d  = lfsr_stepped;
      lfsr_we = 1'b1;
    end

    // The published sample is the pre-step value.
    if (produce) begin
      msg_d  = lfsr_q;
      msg_we = 1'b1;
    end

    // Produce keeps/sets valid; a fire with nothing new behind it clears it.
    if (produce) begin
      val_d  = 1'b1;
      val_we = 1'b1;
    end else if (fire) begin
      val_d  = 1'b0;
      val_we = 1'b1;
    end

    // Natural modular wrap at 2^CNTBITS.
    if (fire) begin
      count_d  = count_q + CNTBITS'(1);
      count_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are straight register taps.
  // ---------------------------------------------------------------------------
  assign out_val = val_q;
  assign out_msg = msg_q;
  assign count   = count_q;

endmodule

// File: tb/tb_random_engine_dpath.sv
// Purpose : self-checking bench for random_engine_dpath using an expected-sample queue.
// Latency : n/a.
// Backpr. : n/a.
module tb_random_engine_dpath;

  localparam logic [15:0] SEEDV = 16'hACE1;
  localparam logic [15:0] TAPSV = 16'hB400;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        lfsr_en   = 1'b0;
  logic        seed_load = 1'b0;
  logic        out_rdy   = 1'b0;
  logic [15:0] seed      = 16'h0000;

  logic        out_val;
  logic [15:0] out_msg;
  logic [31:0] count;
  logic        out_val4;
  logic [15:0] out_msg4;
  logic [3:0]  count4;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [15:0] exp_q[$];
  int unsigned exp_cnt    = 0;
  logic [15:0] mlfsr      = SEEDV;
  bit          mon_on     = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_msg   = 16'h0000;

  always #5 clk = ~clk;

  random_engine_dpath #(
    .NBITS   (16),
    .TAPS    (TAPSV),
    .SEED    (SEEDV),
    .CNTBITS (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lfsr_en   (lfsr_en),
    .seed_load (seed_load),
    .seed      (seed),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .count     (count)
  );

  // Narrow-counter copy driven by the same stimulus, to reach the wrap quickly.
  random_engine_dpath #(
    .NBITS   (16),
    .TAPS    (TAPSV),
    .SEED    (SEEDV),
    .CNTBITS (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .lfsr_en   (lfsr_en),
    .seed_load (seed_load),
    .seed      (seed),
    .out_val   (out_val4),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg4),
    .count     (count4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? TAPSV : 16'h0000);
  endfunction

  task automatic mpush(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mlfsr);
      mlfsr = mstep(mlfsr);
    end
  endtask

  // Drive inputs for one clock, then settle just after the edge.
  task automatic cyc(input logic en, input logic rdy, input logic sl, input logic [15:0] sd);
    lfsr_en   = en;
    out_rdy   = rdy;
    seed_load = sl;
    seed      = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_on    = 1'b0;
    rst       = 1'b0;
    lfsr_en   = 1'b0;
    seed_load = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_val",   32'(out_val), 32'd0);
    chk("rst_msg",   32'(out_msg), 32'd0);
    chk("rst_count", count,        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    mlfsr   = SEEDV;
    mon_on  = 1'b1;
  endtask

  task automatic drain();
    int i;
    lfsr_en   = 1'b0;
    seed_load = 1'b0;
    out_rdy   = 1'b1;
    i = 0;
    while (i < 50 && (exp_q.size() != 0 || out_val)) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_q",   32'(exp_q.size()), 32'd0);
    chk("drain_val", 32'(out_val),      32'd0);
  endtask

  // Scoreboard monitor: samples away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_on && rst) begin
      chk("count",  count,           32'(exp_cnt));
      chk("count4", 32'(count4),     32'(exp_cnt & 32'hF));
      if (prev_stall) begin
        chk("hold_val", 32'(out_val), 32'd1);
        chk("hold_msg", 32'(out_msg), 32'(prev_msg));
      end
      prev_stall = out_val && !out_rdy;
      prev_msg   = out_msg;
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 32'(out_msg), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sample",  32'(out_msg),  32'(e));
          chk("sample4", 32'(out_msg4), 32'(e));
          chk("val4",    32'(out_val4), 32'd1);
        end
        exp_cnt++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    // 1: full-throughput stream from reset.
    do_reset();
    exp_q.push_back(16'hACE1);
    exp_q.push_back(16'hE270);
    exp_q.push_back(16'h7138);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t1_val", 32'(out_val), 32'd1);
    chk("t1_msg", 32'(out_msg), 32'h7138);
    drain();
    chk("t1_count", count, 32'd3);

    // 2: backpressure holds the first sample, then no bubble on release.
    do_reset();
    mpush(3);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t2_val",   32'(out_val), 32'd1);
    chk("t2_msg",   32'(out_msg), 32'hACE1);
    chk("t2_count", count,        32'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t2_nogap_val", 32'(out_val), 32'd1);
    chk("t2_nogap_msg", 32'(out_msg), 32'hE270);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    drain();
    chk("t2_count_end", count, 32'd3);

    // 3: enable pattern 1,0,0,1.
    do_reset();
    exp_q.push_back(16'hACE1);
    exp_q.push_back(16'hE270);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t3_msg0", 32'(out_msg), 32'hACE1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    chk("t3_idle0", 32'(out_val), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    chk("t3_idle1", 32'(out_val), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t3_msg1", 32'(out_msg), 32'hE270);
    drain();
    chk("t3_count", count, 32'd2);

    // 4: reseed mid-stream, then zero seed falls back to the reset seed.
    do_reset();
    exp_q.push_back(16'hACE1);
    exp_q.push_back(16'hE270);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hB400);
    exp_q.push_back(16'hACE1);
    exp_q.push_back(16'hE270);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 16'h0001);
    chk("t4_load_val", 32'(out_val), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_seed1", 32'(out_msg), 32'h0001);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_step1", 32'(out_msg), 32'hB400);
    cyc(1'b1, 1'b1, 1'b1, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_seed0", 32'(out_msg), 32'hACE1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    drain();
    chk("t4_count", count, 32'd6);

    // 5: counter wrap on the 4-bit instance after 16 fires.
    do_reset();
    mpush(16);
    repeat (16) cyc(1'b1, 1'b1, 1'b0, 16'h0);
    drain();
    chk("t5_count",  count,       32'd16);
    chk("t5_count4", 32'(count4), 32'd0);

    // 6: reset while a sample is stalled discards it.
    do_reset();
    mpush(3);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t6_pending", 32'(out_val), 32'd1);
    do_reset();
    exp_q.push_back(16'hACE1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t6_first", 32'(out_msg), 32'hACE1);
    drain();
    chk("t6_count", count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
